spi_burst_arbiter: RTL and testbench
====================================

# spi_burst_arbiter

Shares one byte-level SPI master engine (mode 0, 8-bit frames, single-cycle start pulse, active-low engine enable) among NUM_REQ requesters. Grants are round-robin. Each grant runs a burst of 1..MAX_LEN bytes, and the granted requester's device chip-select is held low for the whole burst. The block sits between the engine and the peripheral clients; the engine's own enable is used only as a busy/completion indicator.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MAX_LEN, 16, maximum bytes per burst; LW = $clog2(MAX_LEN+1)
- CS_SETUP, 2, cycles between chip-select fall and first engine start (≥1)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_i  in  NUM_REQ  request level per requester, held until its done_o
- req_len_i  in  NUM_REQ×LW  burst length in bytes per requester, sampled at grant
- tx_byte_i  in  NUM_REQ×8  next byte to send per requester
- gnt_o  out  NUM_REQ  one-hot grant, held for the whole burst
- tx_pop_o  out  NUM_REQ  1-cycle pulse: current tx_byte_i consumed
- rx_byte_o  out  8  last received byte
- rx_valid_o  out  NUM_REQ  1-cycle pulse: rx_byte_o valid for this requester
- done_o  out  NUM_REQ  1-cycle pulse: burst finished, grant released
- err_o  out  1  1-cycle pulse together with done_o when the engine failed to respond
- spi_cs_n_o  out  NUM_REQ  device chip-selects, active-low
- eng_start_o  out  1  start pulse to the engine
- eng_data_o  out  8  byte to the engine; valid while eng_start_o is high
- eng_cs_n_i  in  1  engine enable (low while a frame is in progress)
- eng_rx_i  in  8  engine received byte

## Operation
- State machine in spi_pkg::arb_state_t: IDLE, SETUP, START, WAIT_LOW, WAIT_HIGH, CAPTURE, RELEASE.
- IDLE: if any req_i is set, the rr_arbiter picks the first requester at or after rr_ptr. The block latches the winner index and len, then:
  - len==0: gnt_o is set and the FSM goes to RELEASE. spi_cs_n_o is never asserted.
  - Otherwise: gnt_o is set, the winner's spi_cs_n_o goes low, and the FSM goes to SETUP.
- SETUP: counts CS_SETUP cycles, then goes to START.
- START:
  - eng_start_o=1 and eng_data_o=tx_byte_i[winner].
  - tx_pop_o[winner]=1.
  - Next state is WAIT_LOW.
- WAIT_LOW: waits for eng_cs_n_i==0, then goes to WAIT_HIGH. If eng_cs_n_i does not go low within ENG_ACK_TIMEOUT (4) cycles, the block sets the error flag and goes to RELEASE.
- WAIT_HIGH: waits for eng_cs_n_i==1, then goes to CAPTURE.
- CAPTURE:
  - rx_byte_o<=eng_rx_i and rx_valid_o[winner] pulses.
  - The remaining count decrements.
  - If remaining was 1, the FSM goes to RELEASE; otherwise it goes back to START.
- RELEASE:
  - spi_cs_n_o all high, gnt_o cleared.
  - done_o[winner] pulses; err_o pulses if the error flag is set.
  - rr_ptr = winner+1 mod NUM_REQ.
  - Next state is IDLE.
- Requests arriving during a burst wait. A req_i that drops before its grant is ignored. A req_i that drops mid-burst does not abort the burst.
- Remaining counter is LW bits. Lengths above MAX_LEN are clamped to MAX_LEN.

## Timing
- Reset values: gnt_o, tx_pop_o, rx_valid_o, done_o, err_o, eng_start_o = 0; rx_byte_o, eng_data_o = 0; spi_cs_n_o all 1; rr_ptr = 0; state IDLE.
- Reset mid-burst forces chip-selects high immediately, with no done_o.
- Request seen in IDLE at cycle T:
  - gnt_o and spi_cs_n_o low from T+1.
  - First eng_start_o at T+1+CS_SETUP.
- Between bytes: eng_start_o is issued the cycle after CAPTURE. CS stays low across inter-byte gaps.
- Simultaneous requests: the lowest index at or after rr_ptr wins.
- Requester re-asserting req_i the cycle after its done_o: it is granted again only if no other request is pending.
- tx_byte_i for byte k+1 must be stable by the cycle after tx_pop_o for byte k is seen.

## Structure
- spi_pkg: arb_state_t, ENG_ACK_TIMEOUT.
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: req, ptr. Output: one-hot grant.
  - Purely combinational.
  - Instantiated once; the FSM registers its result.

## Test plan
- Single request, len=3, bytes A5/3C/F0, engine model echoes inverted → three eng_start_o pulses; rx_valid_o bytes 5A/C3/0F; CS low throughout; one done_o.
- req_i=1111 together, each len=1 → grant order 0,1,2,3. Repeat → order continues 0,1,2,3 with rr_ptr wrap.
- Requester 2 active with len=2 while requester 1 asserts → 1 is granted only after done_o[2]. Requester 2 re-asserts immediately → 1 wins.
- len=0 → gnt_o and done_o pulses; no eng_start_o, no CS assertion.
- Engine never lowers eng_cs_n_i → err_o and done_o 5 cycles after eng_start_o; CS released.
- rst asserted in WAIT_HIGH → spi_cs_n_o all high asynchronously; after release, state IDLE and rr_ptr=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI burst arbiter.
package spi_pkg;

    // Burst sequencing states; see spi_burst_arbiter for the state table.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT_LOW,
        WAIT_HIGH,
        CAPTURE,
        RELEASE
    } arb_state_t;

    // Cycles the engine has to drop its enable after a start pulse.
    localparam int ENG_ACK_TIMEOUT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt
);

    int   idx;
    logic found;

    // Walk the requesters starting at ptr, wrapping once, and grant the first hit.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_burst_arbiter.sv
// Round-robin sharing of one byte-level SPI engine among NUM_REQ clients.
// Each grant runs a burst of bytes with the client's chip-select held low.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no burst; arbitrate and latch winner/length on any request
// SETUP     | chip-select low, counting CS_SETUP cycles before first byte
// START     | pulse the engine start with the winner's current tx byte
// WAIT_LOW  | wait for the engine to drop its enable (times out -> error)
// WAIT_HIGH | frame in flight; wait for the engine enable to rise again
// CAPTURE   | take the received byte, count down remaining bytes
// RELEASE   | drop grant and chip-select, pulse done (and err), advance ptr
module spi_burst_arbiter
    import spi_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  MAX_LEN  = 16,
    parameter int  CS_SETUP = 2,
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*LW-1:0] req_len_i,
    input  logic [NUM_REQ*8-1:0]  tx_byte_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    tx_pop_o,
    output logic [7:0]            rx_byte_o,
    output logic [NUM_REQ-1:0]    rx_valid_o,
    output logic [NUM_REQ-1:0]    done_o,
    output logic                  err_o,
    output logic [NUM_REQ-1:0]    spi_cs_n_o,
    output logic                  eng_start_o,
    output logic [7:0]            eng_data_o,
    input  logic                  eng_cs_n_i,
    input  logic [7:0]            eng_rx_i
);

    localparam int PW   = $clog2(NUM_REQ);
    localparam int TMAX = (CS_SETUP > ENG_ACK_TIMEOUT) ? CS_SETUP : ENG_ACK_TIMEOUT;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_ONE    = LW'(1);
    localparam logic [TW-1:0] SETUP_LOAD = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] ACK_LOAD   = TW'(ENG_ACK_TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_IDX   = PW'(NUM_REQ - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [PW-1:0]     arb_idx;
    logic [LW-1:0]     arb_len_raw;
    logic [LW-1:0]     arb_len;
    logic              any_req;
    logic [PW-1:0]     win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [PW-1:0]     rr_ptr;
    logic [LW-1:0]     rem_cnt;
    logic [TW-1:0]     tmr;
    logic              err_flag;

    assign any_req = |req_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    // Encode the one-hot pick to an index and fetch its clamped burst length.
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = PW'(i);
            end
        end
        arb_len_raw = req_len_i[arb_idx*LW +: LW];
        arb_len     = (arb_len_raw > LEN_MAX) ? LEN_MAX : arb_len_raw;
    end

    // Decode the latched winner index back to one-hot for the per-client strobes.
    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the state-decoded strobes to engine and clients.
    always_comb begin
        state_nxt   = state;
        eng_start_o = 1'b0;
        eng_data_o  = 8'h00;
        tx_pop_o    = '0;
        done_o      = '0;
        err_o       = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = (arb_len == '0) ? RELEASE : SETUP;
                end
            end
            SETUP: begin
                if (tmr == '0) begin
                    state_nxt = START;
                end
            end
            START: begin
                eng_start_o = 1'b1;
                eng_data_o  = tx_byte_i[win_idx*8 +: 8];
                tx_pop_o    = win_onehot;
                state_nxt   = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!eng_cs_n_i) begin
                    state_nxt = WAIT_HIGH;
                end else if (tmr == '0) begin
                    state_nxt = RELEASE;
                end
            end
            WAIT_HIGH: begin
                if (eng_cs_n_i) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = (rem_cnt == LEN_ONE) ? RELEASE : START;
            end
            RELEASE: begin
                done_o    = win_onehot;
                err_o     = err_flag;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Burst bookkeeping: winner latch, grant/chip-select, timers, rx capture, pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_idx    <= '0;
            rr_ptr     <= '0;
            rem_cnt    <= '0;
            tmr        <= '0;
            err_flag   <= 1'b0;
            gnt_o      <= '0;
            spi_cs_n_o <= '1;
            rx_byte_o  <= 8'h00;
            rx_valid_o <= '0;
        end else begin
            rx_valid_o <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_idx  <= arb_idx;
                        rem_cnt  <= arb_len;
                        gnt_o    <= arb_gnt;
                        err_flag <= 1'b0;
                        tmr      <= SETUP_LOAD;
                        if (arb_len != '0) begin
                            spi_cs_n_o <= ~arb_gnt;
                        end
                    end
                end
                SETUP: begin
                    if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end
                end
                START: begin
                    tmr <= ACK_LOAD;
                end
                WAIT_LOW: begin
                    if (eng_cs_n_i) begin
                        if (tmr == '0) begin
                            err_flag <= 1'b1;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    rx_byte_o  <= eng_rx_i;
                    rx_valid_o <= win_onehot;
                    rem_cnt    <= rem_cnt - 1'b1;
                end
                RELEASE: begin
                    gnt_o      <= '0;
                    spi_cs_n_o <= '1;
                    rr_ptr     <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed bench for spi_burst_arbiter with a small echo-inverting engine model.
module tb_spi_burst_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MAX_LEN  = 16;
    localparam int CS_SETUP = 2;
    localparam int LW       = $clog2(MAX_LEN + 1);

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ*LW-1:0] req_len_i;
    logic [NUM_REQ*8-1:0]  tx_byte_i;
    logic [NUM_REQ-1:0]    gnt_o;
    logic [NUM_REQ-1:0]    tx_pop_o;
    logic [7:0]            rx_byte_o;
    logic [NUM_REQ-1:0]    rx_valid_o;
    logic [NUM_REQ-1:0]    done_o;
    logic                  err_o;
    logic [NUM_REQ-1:0]    spi_cs_n_o;
    logic                  eng_start_o;
    logic [7:0]            eng_data_o;
    logic                  eng_cs_n_i;
    logic [7:0]            eng_rx_i;

    int n_err = 0;
    int n_chk = 0;

    bit eng_alive = 1'b1;

    int                 n_start   = 0;
    int                 n_rx      = 0;
    int                 n_done    = 0;
    int                 n_cs_rise = 0;
    int                 n_cs_low  = 0;
    logic [7:0]         rx_log  [64];
    logic [NUM_REQ-1:0] rxw_log [64];
    logic [NUM_REQ-1:0] prev_cs = '1;

    spi_burst_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_LEN  (MAX_LEN),
        .CS_SETUP (CS_SETUP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .req_len_i   (req_len_i),
        .tx_byte_i   (tx_byte_i),
        .gnt_o       (gnt_o),
        .tx_pop_o    (tx_pop_o),
        .rx_byte_o   (rx_byte_o),
        .rx_valid_o  (rx_valid_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .spi_cs_n_o  (spi_cs_n_o),
        .eng_start_o (eng_start_o),
        .eng_data_o  (eng_data_o),
        .eng_cs_n_i  (eng_cs_n_i),
        .eng_rx_i    (eng_rx_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Engine model: enable low one cycle after start, high two cycles later, echoes ~data.
    initial begin
        logic [7:0] d;
        eng_cs_n_i = 1'b1;
        eng_rx_i   = 8'h00;
        forever begin
            @(negedge clk);
            if (eng_start_o === 1'b1 && eng_alive) begin
                d = eng_data_o;
                @(negedge clk);
                eng_cs_n_i = 1'b0;
                repeat (2) @(negedge clk);
                eng_rx_i   = ~d;
                eng_cs_n_i = 1'b1;
            end
        end
    end

    // Event monitor: counts starts, done pulses, chip-select activity, logs rx bytes.
    always @(negedge clk) begin
        if (!rst) begin
            if (eng_start_o === 1'b1) n_start++;
            if (|rx_valid_o) begin
                if (n_rx < 64) begin
                    rx_log[n_rx]  = rx_byte_o;
                    rxw_log[n_rx] = rx_valid_o;
                end
                n_rx++;
            end
            if (|done_o) n_done++;
            if (spi_cs_n_o != '1) n_cs_low++;
            if ((spi_cs_n_o & ~prev_cs) != '0) n_cs_rise++;
        end
        prev_cs = spi_cs_n_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int r, input int l);
        req_len_i[r*LW +: LW] = LW'(l);
    endtask

    task automatic set_tx(input int r, input logic [7:0] b);
        tx_byte_i[r*8 +: 8] = b;
    endtask

    task automatic wait_done(output logic [NUM_REQ-1:0] who, output logic e, output int cyc);
        who = '0;
        e   = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (|done_o) begin
                who = done_o;
                e   = err_o;
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_start(output logic seen);
        seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (eng_start_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [NUM_REQ-1:0] who;
        logic               e;
        logic               seen;
        int                 cyc;
        int                 bi;
        int                 b_start;
        int                 b_rx;
        int                 b_done;
        int                 b_rise;
        int                 b_low;

        rst       = 1'b1;
        req_i     = '0;
        req_len_i = '0;
        tx_byte_i = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_gnt", gnt_o, 0);
        chk("rst_cs", spi_cs_n_o, 4'hF);
        chk("rst_start", eng_start_o, 0);
        chk("rst_pulses", {tx_pop_o, rx_valid_o, done_o, err_o}, 0);
        chk("rst_data", {rx_byte_o, eng_data_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request, 3 bytes, latency and echo
        set_len(0, 3);
        set_tx(0, 8'hA5);
        b_start = n_start;
        b_rx    = n_rx;
        b_rise  = n_cs_rise;
        req_i   = 4'b0001;
        @(negedge clk);
        chk("t1_gnt", gnt_o, 4'b0001);
        chk("t1_cs_low", spi_cs_n_o, 4'b1110);
        chk("t1_no_start_early", eng_start_o, 0);
        @(negedge clk);
        chk("t1_setup_wait", eng_start_o, 0);
        @(negedge clk);
        chk("t1_first_start", eng_start_o, 1);
        chk("t1_first_data", eng_data_o, 8'hA5);
        chk("t1_first_pop", tx_pop_o, 4'b0001);
        set_tx(0, 8'h3C);
        bi  = 1;
        who = '0;
        e   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_pop_o[0]) begin
                bi++;
                set_tx(0, (bi == 2) ? 8'hF0 : 8'h00);
            end
            if (|done_o) begin
                who = done_o;
                e   = err_o;
                break;
            end
        end
        req_i = '0;
        chk("t1_done", who, 4'b0001);
        chk("t1_err", e, 0);
        @(negedge clk);
        chk("t1_rel_gnt", gnt_o, 0);
        chk("t1_rel_cs", spi_cs_n_o, 4'hF);
        @(negedge clk);
        chk("t1_nstart", n_start - b_start, 3);
        chk("t1_nrx", n_rx - b_rx, 3);
        chk("t1_rx0", rx_log[b_rx], 8'h5A);
        chk("t1_rx1", rx_log[b_rx+1], 8'hC3);
        chk("t1_rx2", rx_log[b_rx+2], 8'h0F);
        chk("t1_rx_owner", rxw_log[b_rx+2], 4'b0001);
        chk("t1_cs_one_rise", n_cs_rise - b_rise, 1);

        // Return pointer to 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All four request together, len 1, twice: 0,1,2,3 then wrap to 0,1,2,3
        for (int r = 0; r < NUM_REQ; r++) begin
            set_len(r, 1);
            set_tx(r, 8'(8'h11 * (r + 1)));
        end
        for (int rep = 0; rep < 2; rep++) begin
            req_i = 4'hF;
            for (int k = 0; k < NUM_REQ; k++) begin
                wait_done(who, e, cyc);
                chk($sformatf("t2_order_rep%0d_k%0d", rep, k), who, 1 << k);
                req_i = req_i & ~who;
            end
            @(negedge clk);
        end

        // Requester 1 waits behind a running burst of 2; 2 re-asserts but 1 wins
        set_len(2, 2);
        set_len(1, 1);
        req_i = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt_o == 4'b0100) break;
        end
        chk("t3_gnt2", gnt_o, 4'b0100);
        req_i[1] = 1'b1;
        wait_done(who, e, cyc);
        chk("t3_first_done", who, 4'b0100);
        @(negedge clk);
        chk("t3_gap", gnt_o, 0);
        @(negedge clk);
        chk("t3_regrant_1", gnt_o, 4'b0010);
        wait_done(who, e, cyc);
        chk("t3_second_done", who, 4'b0010);
        req_i[1] = 1'b0;
        wait_done(who, e, cyc);
        chk("t3_third_done", who, 4'b0100);
        req_i = '0;
        @(negedge clk);

        // Zero-length burst on requester 3
        set_len(3, 0);
        b_start = n_start;
        b_low   = n_cs_low;
        req_i   = 4'b1000;
        @(negedge clk);
        chk("t4_gnt", gnt_o, 4'b1000);
        chk("t4_done", done_o, 4'b1000);
        chk("t4_cs", spi_cs_n_o, 4'hF);
        chk("t4_err", err_o, 0);
        req_i = '0;
        @(negedge clk);
        chk("t4_gnt_clear", gnt_o, 0);
        repeat (2) @(negedge clk);
        chk("t4_no_start", n_start - b_start, 0);
        chk("t4_no_cs", n_cs_low - b_low, 0);

        // Engine never answers: error 5 cycles after start
        eng_alive = 1'b0;
        set_len(0, 2);
        b_start = n_start;
        req_i   = 4'b0001;
        wait_start(seen);
        chk("t5_start_seen", seen, 1);
        wait_done(who, e, cyc);
        chk("t5_latency", cyc, 5);
        chk("t5_done", who, 4'b0001);
        chk("t5_err", e, 1);
        req_i = '0;
        @(negedge clk);
        chk("t5_cs_rel", spi_cs_n_o, 4'hF);
        chk("t5_gnt_rel", gnt_o, 0);
        @(negedge clk);
        chk("t5_one_start", n_start - b_start, 1);
        eng_alive = 1'b1;

        // Asynchronous reset during WAIT_HIGH
        set_len(1, 1);
        req_i = 4'b0010;
        wait_start(seen);
        chk("t6_start_seen", seen, 1);
        b_done = n_done;
        @(negedge clk);
        @(negedge clk);
        chk("t6_cs_before", spi_cs_n_o, 4'b1101);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_cs_async", spi_cs_n_o, 4'hF);
        chk("t6_gnt_async", gnt_o, 0);
        req_i = '0;
        repeat (4) @(negedge clk);
        chk("t6_no_done", n_done - b_done, 0);
        rst = 1'b0;
        set_len(0, 1);
        set_len(3, 1);
        req_i = 4'b1001;
        @(negedge clk);
        chk("t6_ptr_zero", gnt_o, 4'b0001);
        wait_done(who, e, cyc);
        chk("t6_done0", who, 4'b0001);
        req_i = 4'b1000;
        wait_done(who, e, cyc);
        chk("t6_done3", who, 4'b1000);
        req_i = '0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
